// File: rtl/dwt_1d_haar_ml_pkg.sv
// Shared types and width/slice helpers for the streaming multi-level Haar DWT.
package dwt_1d_haar_ml_pkg;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } stage_state_t;

    // Detail coefficient width: one sign bit above the sample width.
    function automatic int unsigned coef_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    // MSB of the packed detail slice for 0-based level lvl.
    function automatic int unsigned lvl_msb(input int unsigned lvl, input int unsigned data_w);
        return (lvl + 1) * coef_w(data_w) - 1;
    endfunction

endpackage

// File: rtl/dwt_1d_haar_ml_if.sv
// Sample-in / coefficient-out bundle of the multi-level Haar DWT.
interface dwt_1d_haar_ml_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEVELS = 2
);
    logic [DATA_W-1:0]              din;
    logic                           din_valid;
    logic                           din_last;
    logic [LEVELS*(DATA_W+1)-1:0]   h_o;
    logic [LEVELS-1:0]              h_valid;
    logic [LEVELS-1:0]              h_last;
    logic [DATA_W-1:0]              l_o;
    logic                           l_valid;
    logic                           l_last;

    modport master (
        output din, din_valid, din_last,
        input  h_o, h_valid, h_last, l_o, l_valid, l_last
    );

    modport slave (
        input  din, din_valid, din_last,
        output h_o, h_valid, h_last, l_o, l_valid, l_last
    );
endinterface

// File: rtl/dwt_1d_haar_ml_stage.sv
// One S-transform Haar level: pairs consecutive samples, emits registered H/L one cycle later.
module dwt_haar_stage
    import dwt_1d_haar_ml_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_W-1:0]        i_din,
    input  logic                     i_valid,
    input  logic                     i_last,
    output logic signed [DATA_W:0]   o_h,
    output logic [DATA_W-1:0]        o_l,
    output logic                     o_valid,
    output logic                     o_last
);

    stage_state_t              r_state;
    logic [DATA_W-1:0]         r_a;
    logic signed [DATA_W:0]    r_h;
    logic [DATA_W-1:0]         r_l;
    logic                      r_valid;
    logic                      r_last;

    logic [DATA_W-1:0]         w_a;
    logic signed [DATA_W:0]    w_h;
    logic [DATA_W-1:0]         w_l;

    // In EVEN a lone last sample pairs with itself (symmetric extension).
    assign w_a = (r_state == ST_ODD) ? r_a : i_din;
    assign w_h = $signed({1'b0, w_a}) - $signed({1'b0, i_din});
    // w_h[DATA_W:1] is H>>>1 truncated to DATA_W; the true L fits, so modular add is exact.
    assign w_l = i_din + w_h[DATA_W:1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EVEN;
            r_a     <= '0;
            r_h     <= '0;
            r_l     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                ST_EVEN: begin
                    if (i_valid) begin
                        if (i_last) begin
                            r_h     <= w_h;
                            r_l     <= w_l;
                            r_valid <= 1'b1;
                            r_last  <= 1'b1;
                        end else begin
                            r_a     <= i_din;
                            r_state <= ST_ODD;
                        end
                    end
                end
                ST_ODD: begin
                    if (i_valid) begin
                        r_h     <= w_h;
                        r_l     <= w_l;
                        r_valid <= 1'b1;
                        r_last  <= i_last;
                        r_state <= ST_EVEN;
                    end
                end
                default: r_state <= ST_EVEN;
            endcase
        end
    end

    assign o_h     = r_h;
    assign o_l     = r_l;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/dwt_1d_haar_ml.sv
// Streaming multi-level 1-D Haar DWT: LEVELS cascaded stages chained on their L outputs.
module dwt_1d_haar_ml
    import dwt_1d_haar_ml_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEVELS = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    dwt_1d_haar_ml_if.slave    bus
);

    localparam int unsigned CW = coef_w(DATA_W);

    logic [DATA_W-1:0]        w_l    [LEVELS+1];
    logic [LEVELS:0]          w_v;
    logic [LEVELS:0]          w_last;
    logic signed [CW-1:0]     w_h    [LEVELS];
    logic [LEVELS*CW-1:0]     w_hpack;

    assign w_l[0]    = bus.din;
    assign w_v[0]    = bus.din_valid;
    assign w_last[0] = bus.din_last;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        dwt_haar_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .i_clk   (sys_clk),
            .i_rst_n (sys_rst),
            .i_din   (w_l[k]),
            .i_valid (w_v[k]),
            .i_last  (w_last[k]),
            .o_h     (w_h[k]),
            .o_l     (w_l[k+1]),
            .o_valid (w_v[k+1]),
            .o_last  (w_last[k+1])
        );
    end

    always_comb begin
        w_hpack = '0;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            w_hpack[lvl_msb(k, DATA_W) -: CW] = w_h[k];
        end
    end

    assign bus.h_o     = w_hpack;
    assign bus.h_valid = w_v[LEVELS:1];
    assign bus.h_last  = w_last[LEVELS:1];
    assign bus.l_o     = w_l[LEVELS];
    assign bus.l_valid = w_v[LEVELS];
    assign bus.l_last  = w_last[LEVELS];

endmodule

// File: tb/tb_dwt_1d_haar_ml.sv
// Directed bench for dwt_1d_haar_ml (DATA_W=8, LEVELS=2) with hand-computed coefficients.
module tb_dwt_1d_haar_ml;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic signed [31:0] q1h [$];
    logic               q1l [$];
    logic signed [31:0] q2h [$];
    logic signed [31:0] q2o [$];
    logic               q2l [$];

    always #5 clk = ~clk;

    dwt_1d_haar_ml_if #(.DATA_W(8), .LEVELS(2)) bus ();

    dwt_1d_haar_ml #(
        .DATA_W (8),
        .LEVELS (2)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Present one input, let the edge pass, then sample and log any valid outputs.
    task automatic tick(input logic [7:0] d, input logic v, input logic l);
        bus.din       = d;
        bus.din_valid = v;
        bus.din_last  = l;
        @(posedge clk);
        #1;
        if (bus.h_valid[0]) begin
            q1h.push_back($signed(bus.h_o[8:0]));
            q1l.push_back(bus.h_last[0]);
        end
        if (bus.l_valid) begin
            q2h.push_back($signed(bus.h_o[17:9]));
            q2o.push_back({24'd0, bus.l_o});
            q2l.push_back(bus.l_last);
        end
    endtask

    task automatic flags(input string tag, input logic [1:0] hv, input logic [1:0] hl);
        chk({tag, ".h_valid"}, {30'd0, bus.h_valid}, {30'd0, hv});
        chk({tag, ".h_last"},  {30'd0, bus.h_last},  {30'd0, hl});
        chk({tag, ".l_valid"}, {31'd0, bus.l_valid}, {31'd0, hv[1]});
        chk({tag, ".l_last"},  {31'd0, bus.l_last},  {31'd0, hl[1]});
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;

        // 1: reset held with activity on the input
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(8'(8'hA5 ^ i), 1'b1, 1'(i));
            flags("rst", 2'b00, 2'b00);
            chk("rst.h_o", {14'd0, bus.h_o}, 32'sd0);
            chk("rst.l_o", {24'd0, bus.l_o}, 32'sd0);
        end
        rst = 1'b1;

        // 2: gapless even frame
        tick(8'd10, 1'b1, 1'b0); flags("f2s0", 2'b00, 2'b00);
        tick(8'd20, 1'b1, 1'b0); flags("f2s1", 2'b01, 2'b00);
        chk("f2.h1a", $signed(bus.h_o[8:0]), -32'sd10);
        tick(8'd30, 1'b1, 1'b0); flags("f2s2", 2'b00, 2'b00);
        tick(8'd40, 1'b1, 1'b1); flags("f2s3", 2'b01, 2'b01);
        chk("f2.h1b", $signed(bus.h_o[8:0]), -32'sd10);
        tick(8'd0, 1'b0, 1'b0);  flags("f2s4", 2'b10, 2'b10);
        chk("f2.h2", $signed(bus.h_o[17:9]), -32'sd20);
        chk("f2.l",  {24'd0, bus.l_o}, 32'sd25);
        chk("f2.h1hold", $signed(bus.h_o[8:0]), -32'sd10);

        // 3: odd-length frame, extension at level 1
        tick(8'd100, 1'b1, 1'b0); flags("f3s0", 2'b00, 2'b00);
        tick(8'd50, 1'b1, 1'b0);  flags("f3s1", 2'b01, 2'b00);
        chk("f3.h1a", $signed(bus.h_o[8:0]), 32'sd50);
        tick(8'd7, 1'b1, 1'b1);   flags("f3s2", 2'b01, 2'b01);
        chk("f3.h1b", $signed(bus.h_o[8:0]), 32'sd0);
        tick(8'd0, 1'b0, 1'b0);   flags("f3s3", 2'b10, 2'b10);
        chk("f3.h2", $signed(bus.h_o[17:9]), 32'sd68);
        chk("f3.l",  {24'd0, bus.l_o}, 32'sd41);

        // 4: full-scale extremes
        tick(8'd255, 1'b1, 1'b0); flags("f4s0", 2'b00, 2'b00);
        tick(8'd0, 1'b1, 1'b0);   flags("f4s1", 2'b01, 2'b00);
        chk("f4.h1a", $signed(bus.h_o[8:0]), 32'sd255);
        tick(8'd0, 1'b1, 1'b0);   flags("f4s2", 2'b00, 2'b00);
        tick(8'd255, 1'b1, 1'b1); flags("f4s3", 2'b01, 2'b01);
        chk("f4.h1b", $signed(bus.h_o[8:0]), -32'sd255);
        tick(8'd0, 1'b0, 1'b0);   flags("f4s4", 2'b10, 2'b10);
        chk("f4.h2", $signed(bus.h_o[17:9]), 32'sd0);
        chk("f4.l",  {24'd0, bus.l_o}, 32'sd127);

        // 5: reset mid-frame drops the pending sample
        tick(8'd9, 1'b1, 1'b0);   flags("f5s0", 2'b00, 2'b00);
        rst = 1'b0;
        tick(8'd0, 1'b0, 1'b0);   flags("f5rst", 2'b00, 2'b00);
        chk("f5.rst.h_o", {14'd0, bus.h_o}, 32'sd0);
        chk("f5.rst.l_o", {24'd0, bus.l_o}, 32'sd0);
        rst = 1'b1;
        tick(8'd4, 1'b1, 1'b0);   flags("f5s1", 2'b00, 2'b00);
        tick(8'd6, 1'b1, 1'b1);   flags("f5s2", 2'b01, 2'b01);
        chk("f5.h1", $signed(bus.h_o[8:0]), -32'sd2);
        tick(8'd0, 1'b0, 1'b0);   flags("f5s3", 2'b10, 2'b10);
        chk("f5.h2", $signed(bus.h_o[17:9]), 32'sd0);
        chk("f5.l",  {24'd0, bus.l_o}, 32'sd5);

        // 6: scenario 2 with idle gaps, then a back-to-back frame 8,2,5,1
        q1h.delete(); q1l.delete(); q2h.delete(); q2o.delete(); q2l.delete();
        tick(8'd10, 1'b1, 1'b0);
        repeat ($urandom_range(0, 3)) tick(8'hEE, 1'b0, 1'b1);
        tick(8'd20, 1'b1, 1'b0);
        repeat ($urandom_range(0, 3)) tick(8'hEE, 1'b0, 1'b1);
        tick(8'd30, 1'b1, 1'b0);
        repeat ($urandom_range(0, 3)) tick(8'hEE, 1'b0, 1'b1);
        tick(8'd40, 1'b1, 1'b1);
        tick(8'd8, 1'b1, 1'b0);
        tick(8'd2, 1'b1, 1'b0);
        tick(8'd5, 1'b1, 1'b0);
        tick(8'd1, 1'b1, 1'b1);
        repeat (6) tick(8'd0, 1'b0, 1'b0);

        chk("f6.n1", q1h.size(), 32'sd4);
        chk("f6.n2", q2h.size(), 32'sd2);
        if (q1h.size() == 4) begin
            chk("f6.h1[0]", q1h[0], -32'sd10); chk("f6.last1[0]", {31'd0, q1l[0]}, 32'sd0);
            chk("f6.h1[1]", q1h[1], -32'sd10); chk("f6.last1[1]", {31'd0, q1l[1]}, 32'sd1);
            chk("f6.h1[2]", q1h[2], 32'sd6);   chk("f6.last1[2]", {31'd0, q1l[2]}, 32'sd0);
            chk("f6.h1[3]", q1h[3], 32'sd4);   chk("f6.last1[3]", {31'd0, q1l[3]}, 32'sd1);
        end
        if (q2h.size() == 2) begin
            chk("f6.h2[0]", q2h[0], -32'sd20); chk("f6.l[0]", q2o[0], 32'sd25);
            chk("f6.last2[0]", {31'd0, q2l[0]}, 32'sd1);
            chk("f6.h2[1]", q2h[1], 32'sd2);   chk("f6.l[1]", q2o[1], 32'sd4);
            chk("f6.last2[1]", {31'd0, q2l[1]}, 32'sd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
